palette_reader: RTL
===================

# palette_reader

Avalon-MM read master for the 64-entry × 32-bit palette RAM slave. Accepts a stream of 6-bit pixel indices (valid/ready), issues single-cycle reads to the palette, and delivers the 32-bit colour words on an output stream with full backpressure. Sits between the pixel-index fetch logic and the video output pipeline, on the read side of the palette RAM that the CPU writes.

## Interface
- `FIFO_DEPTH`, default 4: output FIFO entries; power of two, minimum 4.
- `ADDR_W`, default 6: palette address width.
- `DATA_W`, default 32: palette word width.
- `clk` in 1: single clock, shared with the palette slave.
- `reset` in 1: synchronous, active-high.
- `enable` in 1: when low, no new index is accepted; in-flight reads still complete.
- `flush` in 1: synchronous clear of FIFO and counters; takes priority over all traffic.
- `idx_valid` in 1: index input valid.
- `idx_ready` out 1: index input ready.
- `idx_data` in ADDR_W: palette index.
- `idx_last` in 1: last pixel of frame.
- `address` out ADDR_W: palette address.
- `chipselect` out 1: read strobe.
- `write` out 1: tied 0.
- `byteenable` out 4: tied 4'hF.
- `writedata` out DATA_W: tied 0.
- `clken` out 1: tied 1.
- `readdata` in DATA_W: palette data, valid the cycle after `chipselect`.
- `px_valid` out 1: colour output valid.
- `px_ready` in 1: downstream ready.
- `px_data` out DATA_W: colour word.
- `px_last` out 1: frame end, aligned with `px_data`.
- `busy` out 1: read pending or FIFO non-empty.
- `frame_count` out 16: completed frames (popped `px_last` beats), wraps at 16'hFFFF→0.

## Operation
- Accept occurs when `idx_valid && idx_ready`. In the same cycle, `chipselect`=1 and `address`=`idx_data` (combinational). With no accept, `chipselect`=0 and `address` holds its last value.
- `idx_ready = enable && !flush && (fifo_count + pending) < FIFO_DEPTH`, where `pending` is a 1-bit register set on accept.
- Cycle after accept: `readdata` and the registered `idx_last` are pushed into the FIFO. Pushes are credit-guaranteed; overflow is impossible by construction, and the bench asserts this.
- FIFO pop occurs on `px_valid && px_ready`. A simultaneous push and pop leaves `fifo_count` unchanged. Read/write pointers wrap modulo FIFO_DEPTH.
- `frame_count` increments on a pop with `px_last`=1.
- `flush`: clears FIFO pointers, `fifo_count`, and `pending`. A read issued the previous cycle is discarded and not pushed. `frame_count` is not cleared by flush.
- Deasserting `enable` mid-frame stops accepts only. The FIFO continues draining.
- `busy = pending || fifo_count != 0`.

## Timing
- Reset values: `idx_ready`=0 during reset, `chipselect`=0, `address`=0, `px_valid`=0, `px_data`=0, `px_last`=0, `busy`=0, `frame_count`=0. FIFO is empty and `pending`=0.
- Latency: index accepted at cycle N, `px_valid` first high at N+2 (FIFO output is registered).
- Throughput: one index per cycle sustained while `px_ready`=1 (requires FIFO_DEPTH ≥ 3).
- `px_data`/`px_last` hold stable while `px_valid && !px_ready`.
- Reset or flush asserted while `px_valid`=1 drops `px_valid` the next cycle with no pop counted.

## Structure
- Shared package `palette_pkg` holds `PAL_ADDR_W`=6, `PAL_DATA_W`=32, `PAL_DEPTH`=64, and the `pal_word_t` typedef.
- One sub-module, `palette_reader_fifo`: synchronous FIFO of width DATA_W+1, exposing count, push, and pop, with a registered output.
- Top level contains the accept/credit logic, the `pending` register, and the frame counter.

## Test plan
- Reset, then palette preloaded with entry k = 32'hC0DE_0000+k. Indices 0,1,63 at one per cycle with `px_ready`=1 → `px_data` C0DE0000, C0DE0001, C0DE003F at cycles N+2..N+4.
- 64-index frame with `idx_last` on index 63 and `px_ready`=1 → 64 contiguous beats, `px_last` on the 64th, `frame_count`=1, `busy`=0 two cycles after the last pop.
- `px_ready`=0 while 8 indices are offered → exactly 4 accepted, `idx_ready`=0 afterwards, `px_data` stable. Release `px_ready` → remaining indices resume with no loss or duplication.
- `flush` asserted the cycle after an accept with 3 words queued → next cycle `px_valid`=0 and `busy`=0. The discarded read never appears at the output.
- `enable` dropped after 10 of 20 indices → exactly 10 outputs, `chipselect` stays 0. Re-enable → indices 10..19 delivered in order.
- 65536 one-pixel frames (`idx_last`=1 on every index) → `frame_count` wraps to 0.

Source files
------------

// File: rtl/palette_pkg.sv
// Shared palette RAM geometry and word type, used by the palette read path.
package palette_pkg;
    localparam int PAL_ADDR_W = 6;
    localparam int PAL_DATA_W = 32;
    localparam int PAL_DEPTH  = 64;

    typedef logic [PAL_DATA_W-1:0] pal_word_t;
endpackage

// File: rtl/palette_reader_fifo.sv
// Synchronous FIFO with flop storage; head entry is driven straight from registers.
module palette_reader_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 33,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [CNT_W-1:0] count_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q, rd_q;
    logic [CNT_W-1:0] cnt_q;
    logic             do_pop;

    assign do_pop  = pop_i && (cnt_q != '0);
    assign count_o = cnt_q;
    assign valid_o = (cnt_q != '0);
    assign data_o  = mem_q[rd_q];

    // Flush only rewinds pointers; stale storage is invisible once count is zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_q] <= push_data_i;
                wr_q        <= wr_q + 1'b1;
            end
            if (do_pop) rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + CNT_W'(push_i) - CNT_W'(do_pop);
        end
    end
endmodule

// File: rtl/palette_reader.sv
// Avalon-MM read master: index stream in, palette lookups out, colour stream back with backpressure.
module palette_reader
    import palette_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = PAL_ADDR_W,
    parameter int DATA_W     = PAL_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              flush,
    input  logic              idx_valid,
    output logic              idx_ready,
    input  logic [ADDR_W-1:0] idx_data,
    input  logic              idx_last,
    output logic [ADDR_W-1:0] address,
    output logic              chipselect,
    output logic              write,
    output logic [3:0]        byteenable,
    output logic [DATA_W-1:0] writedata,
    output logic              clken,
    input  logic [DATA_W-1:0] readdata,
    output logic              px_valid,
    input  logic              px_ready,
    output logic [DATA_W-1:0] px_data,
    output logic              px_last,
    output logic              busy,
    output logic [15:0]       frame_count
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic              accept;
    logic              pending_q;
    logic              last_q;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       frame_q;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W:0]    inflight;
    logic [DATA_W:0]   fifo_dout;

    // A read is only launched when a FIFO slot is reserved for its data, so pushes never overflow.
    assign inflight  = {1'b0, fifo_count} + {{CNT_W{1'b0}}, pending_q};
    assign idx_ready = !reset && enable && !flush && (inflight < (CNT_W+1)'(FIFO_DEPTH));
    assign accept    = idx_valid && idx_ready;

    assign chipselect = accept;
    assign address    = accept ? idx_data : addr_q;
    assign write      = 1'b0;
    assign byteenable = 4'hF;
    assign writedata  = '0;
    assign clken      = 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q <= 1'b0;
            last_q    <= 1'b0;
            addr_q    <= '0;
            frame_q   <= '0;
        end else begin
            pending_q <= accept;
            if (accept) begin
                addr_q <= idx_data;
                last_q <= idx_last;
            end
            if (px_valid && px_ready && px_last && !flush) frame_q <= frame_q + 16'd1;
        end
    end

    palette_reader_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W + 1)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .flush_i     (flush),
        .push_i      (pending_q),
        .push_data_i ({last_q, readdata}),
        .pop_i       (px_valid && px_ready),
        .count_o     (fifo_count),
        .valid_o     (px_valid),
        .data_o      (fifo_dout)
    );

    assign px_data     = fifo_dout[DATA_W-1:0];
    assign px_last     = fifo_dout[DATA_W];
    assign busy        = pending_q || (fifo_count != '0);
    assign frame_count = frame_q;
endmodule
